// File: rtl/mem_port_arbiter_if.sv
// Requester handshakes and the single-port memory bus of mem_port_arbiter.
// slave = arbiter side; master = requesters plus memory (environment side).
interface mem_port_arbiter_if;
   logic        if_req_valid;
   logic [31:0] if_req_addr;
   logic        if_req_ready;
   logic        if_flush;
   logic        if_rsp_valid;
   logic [31:0] if_rsp_data;

   logic        d_req_valid;
   logic        d_req_we;
   logic [31:0] d_req_addr;
   logic [31:0] d_req_wdata;
   logic [3:0]  d_req_wstrb;
   logic        d_req_ready;
   logic        d_rsp_valid;
   logic [31:0] d_rsp_data;

   logic        mem_en;
   logic        mem_we;
   logic [31:0] mem_addr;
   logic [31:0] mem_wdata;
   logic [3:0]  mem_wstrb;
   logic [31:0] mem_rdata;

   logic        busy;
   logic        owner;

   modport slave (
      input  if_req_valid, if_req_addr, if_flush,
      input  d_req_valid, d_req_we, d_req_addr, d_req_wdata, d_req_wstrb,
      input  mem_rdata,
      output if_req_ready, if_rsp_valid, if_rsp_data,
      output d_req_ready, d_rsp_valid, d_rsp_data,
      output mem_en, mem_we, mem_addr, mem_wdata, mem_wstrb,
      output busy, owner
   );

   modport master (
      output if_req_valid, if_req_addr, if_flush,
      output d_req_valid, d_req_we, d_req_addr, d_req_wdata, d_req_wstrb,
      output mem_rdata,
      input  if_req_ready, if_rsp_valid, if_rsp_data,
      input  d_req_ready, d_rsp_valid, d_rsp_data,
      input  mem_en, mem_we, mem_addr, mem_wdata, mem_wstrb,
      input  busy, owner
   );
endinterface

// File: rtl/mem_port_arbiter.sv
// Shares one single-port memory between instruction fetch and MEM-stage data,
// one transaction at a time, data-first with a fetch starvation guard.
module mem_port_arbiter #(
   parameter int unsigned MEM_LATENCY  = 1,
   parameter int unsigned STARVE_LIMIT = 4
) (
   input  logic              clk,
   input  logic              rst,
   mem_port_arbiter_if.slave bus
);
   typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_e;

   localparam logic [3:0] LAT  = 4'(MEM_LATENCY);
   localparam logic [3:0] SLIM = 4'(STARVE_LIMIT);

   state_e      state_q, state_d;
   logic [3:0]  wait_cnt_q, wait_cnt_d;
   logic [3:0]  starve_cnt_q, starve_cnt_d;
   logic        owner_q, owner_d;
   logic        we_q, we_d;
   logic        cancel_q, cancel_d;
   logic [31:0] addr_q, addr_d;
   logic [31:0] wdata_q, wdata_d;
   logic [3:0]  wstrb_q, wstrb_d;
   logic [31:0] if_rdata_q, if_rdata_d;
   logic [31:0] d_rdata_q, d_rdata_d;

   logic        idle, starve_hit, d_win, f_win;
   logic        if_ready, d_ready;
   logic        mem_en, mem_we, if_rsp_valid, d_rsp_valid;
   logic [3:0]  mem_wstrb;

   // Readys are held low while rst is asserted so nothing looks accepted in reset.
   assign idle       = (state_q == IDLE) && !rst;
   assign starve_hit = bus.if_req_valid && (starve_cnt_q == SLIM);
   assign d_win      = bus.d_req_valid && !starve_hit;
   assign f_win      = !d_win && bus.if_req_valid;
   assign if_ready   = idle && f_win && !bus.if_flush;
   assign d_ready    = idle && d_win;

   always_comb begin
      state_d      = state_q;
      wait_cnt_d   = wait_cnt_q;
      starve_cnt_d = starve_cnt_q;
      owner_d      = owner_q;
      we_d         = we_q;
      cancel_d     = cancel_q;
      addr_d       = addr_q;
      wdata_d      = wdata_q;
      wstrb_d      = wstrb_q;
      if_rdata_d   = if_rdata_q;
      d_rdata_d    = d_rdata_q;
      mem_en       = 1'b0;
      mem_we       = 1'b0;
      mem_wstrb    = 4'h0;
      if_rsp_valid = 1'b0;
      d_rsp_valid  = 1'b0;

      unique case (state_q)
         IDLE: begin
            if (d_ready) begin
               owner_d      = 1'b1;
               we_d         = bus.d_req_we;
               addr_d       = bus.d_req_addr;
               wdata_d      = bus.d_req_wdata;
               wstrb_d      = bus.d_req_wstrb;
               state_d      = ISSUE;
               starve_cnt_d = !bus.if_req_valid ? 4'h0 :
                              (starve_cnt_q == SLIM) ? starve_cnt_q : starve_cnt_q + 4'd1;
            end else if (if_ready) begin
               owner_d      = 1'b0;
               we_d         = 1'b0;
               addr_d       = bus.if_req_addr;
               wstrb_d      = 4'h0;
               state_d      = ISSUE;
               starve_cnt_d = 4'h0;
            end else if (!bus.if_req_valid) begin
               starve_cnt_d = 4'h0;
            end
         end
         ISSUE: begin
            mem_en    = 1'b1;
            mem_we    = we_q;
            mem_wstrb = wstrb_q;
            if (we_q) begin
               d_rdata_d = 32'h0;
               state_d   = RESP;
            end else begin
               wait_cnt_d = LAT;
               state_d    = WAIT;
            end
         end
         WAIT: begin
            wait_cnt_d = wait_cnt_q - 4'd1;
            // Only the final WAIT cycle carries valid read data.
            if (wait_cnt_q == 4'd1) begin
               if (owner_q) d_rdata_d  = bus.mem_rdata;
               else         if_rdata_d = bus.mem_rdata;
               state_d = RESP;
            end
         end
         RESP: begin
            if (owner_q) d_rsp_valid  = 1'b1;
            else         if_rsp_valid = !cancel_q && !bus.if_flush;
            state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase

      if ((state_q != IDLE) && !owner_q && bus.if_flush) cancel_d = 1'b1;
      if (state_d == IDLE) cancel_d = 1'b0;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q      <= IDLE;
         wait_cnt_q   <= 4'h0;
         starve_cnt_q <= 4'h0;
         owner_q      <= 1'b0;
         we_q         <= 1'b0;
         cancel_q     <= 1'b0;
         addr_q       <= 32'h0;
         wdata_q      <= 32'h0;
         wstrb_q      <= 4'h0;
         if_rdata_q   <= 32'h0;
         d_rdata_q    <= 32'h0;
      end else begin
         state_q      <= state_d;
         wait_cnt_q   <= wait_cnt_d;
         starve_cnt_q <= starve_cnt_d;
         owner_q      <= owner_d;
         we_q         <= we_d;
         cancel_q     <= cancel_d;
         addr_q       <= addr_d;
         wdata_q      <= wdata_d;
         wstrb_q      <= wstrb_d;
         if_rdata_q   <= if_rdata_d;
         d_rdata_q    <= d_rdata_d;
      end
   end

   assign bus.if_req_ready = if_ready;
   assign bus.d_req_ready  = d_ready;
   assign bus.if_rsp_valid = if_rsp_valid;
   assign bus.d_rsp_valid  = d_rsp_valid;
   assign bus.if_rsp_data  = if_rdata_q;
   assign bus.d_rsp_data   = d_rdata_q;
   assign bus.mem_en       = mem_en;
   assign bus.mem_we       = mem_we;
   assign bus.mem_wstrb    = mem_wstrb;
   assign bus.mem_addr     = addr_q;
   assign bus.mem_wdata    = wdata_q;
   assign bus.busy         = (state_q != IDLE);
   assign bus.owner        = owner_q;
endmodule

// File: tb/tb_mem_port_arbiter.sv
// Bench for mem_port_arbiter: directed table, corner sequences and random traffic
// checked every cycle against a transaction-level reference model.
module tb_mem_port_arbiter;
   localparam int L  = 3;
   localparam int SL = 4;

   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   mem_port_arbiter_if bus ();
   mem_port_arbiter #(.MEM_LATENCY(L), .STARVE_LIMIT(SL)) dut (.clk(clk), .rst(rst), .bus(bus));

   int n_tests = 0;
   int n_fail  = 0;

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: actual %0h, required %0h at %0t", nm, act, exp, $time);
      end
   endtask

   task automatic timeout_fail(input string nm);
      n_tests++;
      n_fail++;
      $display("FAIL %s: actual timeout, required event within bound at %0t", nm, $time);
   endtask

   function automatic logic [31:0] pre(input logic [31:0] a);
      if (a == 32'h10)  return 32'h0050_0093;
      if (a == 32'h200) return 32'h1234_5678;
      return a ^ 32'hC0DE_0000;
   endfunction

   function automatic logic [31:0] merge(input logic [31:0] o, input logic [31:0] w, input logic [3:0] s);
      logic [31:0] r;
      r = o;
      for (int b = 0; b < 4; b++) if (s[b]) r[8*b +: 8] = w[8*b +: 8];
      return r;
   endfunction

   // ---------------- memory: data valid only MEM_LATENCY cycles after mem_en ----------
   logic [31:0] bmem [0:1023];
   logic [31:0] raddr;
   int          since;
   bit          mem_init = 1'b0;

   always @(posedge clk or posedge rst) begin
      if (!mem_init) begin
         for (int i = 0; i < 1024; i++) bmem[i] <= pre(32'(i) << 2);
         mem_init <= 1'b1;
      end
      if (rst) begin
         since         <= 0;
         bus.mem_rdata <= 32'hBAD0_0000;
      end else begin
         if (bus.mem_en && bus.mem_we)
            bmem[bus.mem_addr[11:2]] <= merge(bmem[bus.mem_addr[11:2]], bus.mem_wdata, bus.mem_wstrb);
         if (bus.mem_en && !bus.mem_we) begin
            since         <= 1;
            raddr         <= bus.mem_addr;
            bus.mem_rdata <= (L == 1) ? bmem[bus.mem_addr[11:2]] : 32'hBAD0_0001;
         end else if (since != 0) begin
            since         <= since + 1;
            bus.mem_rdata <= (since + 1 == L) ? bmem[raddr[11:2]] : (32'hBAD0_0000 | 32'(since + 1));
         end else begin
            bus.mem_rdata <= 32'hBAD0_0000;
         end
      end
   end

   // ---------------- reference model: one transaction record + arithmetic timing ----
   logic [31:0] ref_mem [0:1023];
   initial for (int i = 0; i < 1024; i++) ref_mem[i] = pre(32'(i) << 2);

   int          cyc = 0, m_resp = 0, m_acc = -10, m_starve = 0;
   bit          m_fetch, m_we, m_owner, m_cancel;
   logic [31:0] m_addr, m_wdata, m_rdata, m_ifdata, m_ddata;
   logic [3:0]  m_wstrb;

   always @(negedge clk) begin : monitor
      bit idle, swin, e_dwin, e_ifr, e_dr, e_ifv, e_dv, e_en;
      cyc++;
      if (rst) begin
         chk("rst_ctl", {bus.if_req_ready, bus.d_req_ready, bus.if_rsp_valid, bus.d_rsp_valid,
                         bus.mem_en, bus.mem_we, bus.mem_wstrb, bus.busy, bus.owner}, 64'h0);
         chk("rst_rsp_data", {bus.if_rsp_data, bus.d_rsp_data}, 64'h0);
         m_resp = cyc; m_acc = cyc - 10; m_starve = 0;
         m_fetch = 0; m_we = 0; m_owner = 0; m_cancel = 0;
         m_addr = 0; m_wdata = 0; m_wstrb = 0; m_ifdata = 0; m_ddata = 0;
      end else begin
         idle   = (cyc > m_resp);
         swin   = bus.if_req_valid && (m_starve == SL);
         e_dwin = bus.d_req_valid && !swin;
         e_ifr  = idle && !e_dwin && bus.if_req_valid && !bus.if_flush;
         e_dr   = idle && e_dwin;
         if (!idle && m_fetch && bus.if_flush) m_cancel = 1;
         e_ifv = 0; e_dv = 0;
         if (cyc == m_resp) begin
            if (m_fetch) begin e_ifv = !m_cancel; m_ifdata = m_rdata; end
            else begin e_dv = 1; m_ddata = m_we ? 32'h0 : m_rdata; end
         end
         e_en = !idle && (cyc == m_acc + 1);
         chk("ready", {bus.if_req_ready, bus.d_req_ready}, {e_ifr, e_dr});
         chk("rsp_valid", {bus.if_rsp_valid, bus.d_rsp_valid}, {e_ifv, e_dv});
         chk("busy_owner", {bus.busy, bus.owner}, {!idle, m_owner});
         chk("mem_ctl", {bus.mem_en, bus.mem_we, bus.mem_wstrb},
             {e_en, e_en && m_we, e_en ? m_wstrb : 4'h0});
         chk("mem_addr", bus.mem_addr, m_addr);
         if (e_en && m_we) chk("mem_wdata", bus.mem_wdata, m_wdata);
         chk("rsp_data", {bus.if_rsp_data, bus.d_rsp_data}, {m_ifdata, m_ddata});
         if (idle) begin
            if (e_dr) begin
               m_acc = cyc; m_fetch = 0; m_owner = 1; m_cancel = 0;
               m_we = bus.d_req_we; m_addr = bus.d_req_addr;
               m_wdata = bus.d_req_wdata; m_wstrb = bus.d_req_wstrb;
               m_resp = cyc + 2 + (m_we ? 0 : L);
               m_rdata = ref_mem[m_addr[11:2]];
               if (m_we) ref_mem[m_addr[11:2]] = merge(m_rdata, m_wdata, m_wstrb);
               m_starve = !bus.if_req_valid ? 0 : (m_starve < SL ? m_starve + 1 : SL);
            end else if (e_ifr) begin
               m_acc = cyc; m_fetch = 1; m_owner = 0; m_cancel = 0;
               m_we = 0; m_addr = bus.if_req_addr; m_wstrb = 0;
               m_resp = cyc + 2 + L;
               m_rdata = ref_mem[m_addr[11:2]];
               m_starve = 0;
            end else if (!bus.if_req_valid) begin
               m_starve = 0;
            end
         end
      end
   end

   // ---------------- directed helpers ----------------
   task automatic wait_rsp(input bit f, output int lat, output logic [31:0] rd);
      lat = 0; rd = 'x;
      do begin
         @(negedge clk);
         lat++;
      end while (!(f ? bus.if_rsp_valid : bus.d_rsp_valid) && lat < 40);
      if (lat >= 40) timeout_fail("rsp_wait");
      else rd = f ? bus.if_rsp_data : bus.d_rsp_data;
   endtask

   task automatic do_req(input bit f, input bit we, input logic [31:0] a, input logic [31:0] wd,
                         input logic [3:0] st, output int lat, output logic [31:0] rd);
      int k;
      @(posedge clk); #1;
      if (f) begin bus.if_req_valid = 1; bus.if_req_addr = a; end
      else begin
         bus.d_req_valid = 1; bus.d_req_we = we; bus.d_req_addr = a;
         bus.d_req_wdata = wd; bus.d_req_wstrb = st;
      end
      k = 0;
      do begin @(negedge clk); k++; end
      while (!(f ? bus.if_req_ready : bus.d_req_ready) && k < 40);
      if (k >= 40) timeout_fail("accept_wait");
      @(posedge clk); #1;
      bus.if_req_valid = 0; bus.d_req_valid = 0;
      wait_rsp(f, lat, rd);
   endtask

   task automatic wait_idle();
      int k;
      k = 0;
      do begin @(negedge clk); k++; end while (bus.busy && k < 60);
      if (k >= 60) timeout_fail("idle_wait");
   endtask

   typedef struct {
      bit          f;
      bit          we;
      logic [31:0] addr;
      logic [31:0] wdata;
      logic [3:0]  strb;
      logic [31:0] exp_data;
      int          exp_lat;
   } vec_t;

   vec_t tbl [7];

   initial begin
      #1_000_000;
      $display("FAIL watchdog: actual no finish, required finish by %0t", $time);
      $fatal(1, "watchdog");
   end

   initial begin
      int          lat, pulses, ng, k;
      logic [31:0] rd;
      logic [9:0]  g, gexp;

      tbl[0] = '{1'b1, 1'b0, 32'h10,  32'h0,        4'h0, 32'h0050_0093, 2 + L};
      tbl[1] = '{1'b0, 1'b1, 32'h100, 32'hDEAD_BEEF, 4'hF, 32'h0,         2};
      tbl[2] = '{1'b0, 1'b0, 32'h100, 32'h0,        4'h0, 32'hDEAD_BEEF, 2 + L};
      tbl[3] = '{1'b0, 1'b1, 32'h100, 32'h1122_3344, 4'h5, 32'h0,         2};
      tbl[4] = '{1'b0, 1'b0, 32'h100, 32'h0,        4'hF, 32'hDE22_BE44, 2 + L};
      tbl[5] = '{1'b0, 1'b0, 32'h200, 32'h0,        4'h0, 32'h1234_5678, 2 + L};
      tbl[6] = '{1'b1, 1'b0, 32'h100, 32'h0,        4'h0, 32'hDE22_BE44, 2 + L};

      bus.if_req_valid = 0; bus.if_req_addr = 0; bus.if_flush = 0;
      bus.d_req_valid = 0; bus.d_req_we = 0; bus.d_req_addr = 0;
      bus.d_req_wdata = 0; bus.d_req_wstrb = 0;

      repeat (2) @(negedge clk);
      chk("reset_state", {bus.busy, bus.owner, bus.mem_en, bus.mem_addr}, 64'h0);
      @(posedge clk); #1 rst = 0;

      // table of single transactions: latency and returned data
      foreach (tbl[i]) begin
         do_req(tbl[i].f, tbl[i].we, tbl[i].addr, tbl[i].wdata, tbl[i].strb, lat, rd);
         chk($sformatf("vec%0d_latency", i), lat, tbl[i].exp_lat);
         chk($sformatf("vec%0d_data", i), rd, tbl[i].exp_data);
      end

      // simultaneous requests: data first, fetch accepted after the write completes
      @(posedge clk); #1;
      bus.if_req_valid = 1; bus.if_req_addr = 32'h20;
      bus.d_req_valid = 1; bus.d_req_we = 1; bus.d_req_addr = 32'h100;
      bus.d_req_wdata = 32'hDEAD_BEEF; bus.d_req_wstrb = 4'hF;
      @(negedge clk);
      chk("simul_grant", {bus.if_req_ready, bus.d_req_ready}, 2'b01);
      @(posedge clk); #1 bus.d_req_valid = 0;
      @(negedge clk);
      chk("simul_issue", {bus.mem_en, bus.mem_we, bus.mem_addr}, {2'b11, 32'h100});
      @(negedge clk);
      chk("simul_d_rsp", {bus.d_rsp_valid, bus.d_rsp_data}, {1'b1, 32'h0});
      @(negedge clk);
      chk("simul_fetch_ready", bus.if_req_ready, 1'b1);
      @(posedge clk); #1 bus.if_req_valid = 0;
      wait_rsp(1'b1, lat, rd);
      chk("simul_fetch_latency", lat, 2 + L);
      chk("simul_fetch_data", rd, pre(32'h20));

      // starvation guard with both requesters held high
      @(posedge clk); #1;
      bus.if_req_valid = 1; bus.if_req_addr = 32'h40;
      bus.d_req_valid = 1; bus.d_req_we = 1; bus.d_req_addr = 32'h300;
      bus.d_req_wdata = 32'hA5A5_A5A5; bus.d_req_wstrb = 4'hF;
      ng = 0; k = 0; g = '0;
      while (ng < 10 && k < 400) begin
         @(negedge clk); k++;
         if (bus.if_req_ready || bus.d_req_ready) begin
            g[ng] = bus.if_req_ready;
            ng++;
         end
      end
      if (ng < 10) timeout_fail("starve_grants");
      for (int i = 0; i < 10; i++) gexp[i] = ((i % (SL + 1)) == SL);
      chk("starve_pattern", g, gexp);
      @(posedge clk); #1;
      bus.if_req_valid = 0; bus.d_req_valid = 0;
      wait_idle();

      // fetch flushed during WAIT: no response, FSM timing unchanged
      @(posedge clk); #1;
      bus.if_req_valid = 1; bus.if_req_addr = 32'h10;
      @(negedge clk);
      chk("flush_accept", bus.if_req_ready, 1'b1);
      @(posedge clk); #1 bus.if_req_valid = 0;
      @(posedge clk); #1 bus.if_flush = 1;
      @(posedge clk); #1 bus.if_flush = 0;
      pulses = 0;
      for (int i = 0; i <= L; i++) begin
         if (i > 0) @(posedge clk);
         @(negedge clk);
         pulses += int'(bus.if_rsp_valid);
         if (i == L - 1) chk("flush_resp_busy", bus.busy, 1'b1);
         if (i == L)     chk("flush_idle_on_time", bus.busy, 1'b0);
      end
      chk("flush_no_rsp", pulses, 0);
      do_req(1'b1, 1'b0, 32'h10, 32'h0, 4'h0, lat, rd);
      chk("post_flush_latency", lat, 2 + L);
      chk("post_flush_data", rd, 32'h0050_0093);

      // reset asserted while a data read is in WAIT
      @(posedge clk); #1;
      bus.d_req_valid = 1; bus.d_req_we = 0; bus.d_req_addr = 32'h200;
      @(negedge clk);
      chk("rst_test_accept", bus.d_req_ready, 1'b1);
      @(posedge clk); #1 bus.d_req_valid = 0;
      @(posedge clk); #1 rst = 1;
      #1;
      chk("rst_async_ctl", {bus.if_req_ready, bus.d_req_ready, bus.if_rsp_valid, bus.d_rsp_valid,
                            bus.mem_en, bus.mem_we, bus.mem_wstrb, bus.busy, bus.owner}, 64'h0);
      chk("rst_async_data", {bus.mem_addr, bus.d_rsp_data}, 64'h0);
      repeat (2) @(posedge clk);
      #1 rst = 0;
      pulses = 0;
      for (int i = 0; i < L + 3; i++) begin
         @(negedge clk);
         pulses += int'(bus.d_rsp_valid) + int'(bus.if_rsp_valid);
      end
      chk("rst_no_rsp", pulses, 0);
      do_req(1'b0, 1'b0, 32'h200, 32'h0, 4'h0, lat, rd);
      chk("post_rst_latency", lat, 2 + L);
      chk("post_rst_data", rd, 32'h1234_5678);

      // random traffic, checked cycle by cycle by the monitor
      for (int i = 0; i < 3000; i++) begin
         @(posedge clk); #1;
         bus.if_req_valid = ($urandom_range(0, 2) != 0);
         bus.if_req_addr  = 32'h400 + (32'($urandom_range(0, 31)) << 2);
         bus.if_flush     = ($urandom_range(0, 7) == 0);
         bus.d_req_valid  = ($urandom_range(0, 2) != 0);
         bus.d_req_we     = $urandom_range(0, 1) == 1;
         bus.d_req_addr   = 32'h400 + (32'($urandom_range(0, 31)) << 2);
         bus.d_req_wdata  = $urandom;
         bus.d_req_wstrb  = 4'($urandom_range(0, 15));
      end
      @(posedge clk); #1;
      bus.if_req_valid = 0; bus.d_req_valid = 0; bus.if_flush = 0;
      wait_idle();
      repeat (2) @(negedge clk);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end
endmodule
